// File: rtl/ascon_permutation_core.sv
// ascon_permutation_core
//   Iterative Ascon-p[rnd] permutation engine. Holds one 320-bit state and
//   applies rnd rounds (0..16, larger values clamped to 16). Each round is
//   constant addition, the bit-sliced 5-bit S-box, then linear diffusion.
//   UNROLL rounds are evaluated combinationally per clock.
//
// Parameters
//   UNROLL       rounds evaluated per clock, 1..16
//
// Ports
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset
//   in_valid_i   request valid
//   in_ready_o   core can accept a request (IDLE, or DONE with out_ready_i)
//   state_i      state to permute, word j is S_j (5 x 64 bits)
//   rnd_i        round count
//   out_valid_o  result valid (registered)
//   out_ready_i  consumer accepts the result
//   state_o      permuted state (registered)
//   busy_o       high while rounds are being applied
module ascon_permutation_core #(
  parameter int unsigned UNROLL = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [4:0][63:0] state_i,
  input  logic [4:0]       rnd_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [4:0][63:0] state_o,
  output logic             busy_o
);

  typedef logic [4:0][63:0] ascon_state_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } fsm_e;

  localparam logic [4:0] UNROLL_L = 5'(UNROLL);
  localparam logic [4:0] MAX_RND  = 5'd16;

  // --------------------------------------------------------------------------
  // Round primitives
  // --------------------------------------------------------------------------
  function automatic logic [7:0] round_const(input logic [4:0] i);
    logic [7:0] c;
    case (i)
      5'd0:    c = 8'h3c;
      5'd1:    c = 8'h2d;
      5'd2:    c = 8'h1e;
      5'd3:    c = 8'h0f;
      5'd4:    c = 8'hf0;
      5'd5:    c = 8'he1;
      5'd6:    c = 8'hd2;
      5'd7:    c = 8'hc3;
      5'd8:    c = 8'hb4;
      5'd9:    c = 8'ha5;
      5'd10:   c = 8'h96;
      5'd11:   c = 8'h87;
      5'd12:   c = 8'h78;
      5'd13:   c = 8'h69;
      5'd14:   c = 8'h5a;
      5'd15:   c = 8'h4b;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Bit-sliced S-box: every bit position j forms one 5-bit S-box input
  // {S0[j], S1[j], S2[j], S3[j], S4[j]}.
  function automatic ascon_state_t sbox_layer(input ascon_state_t s);
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    ascon_state_t r;
    x0 = s[0];
    x1 = s[1];
    x2 = s[2];
    x3 = s[3];
    x4 = s[4];
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    r[0] = x0;
    r[1] = x1;
    r[2] = x2;
    r[3] = x3;
    r[4] = x4;
    return r;
  endfunction

  function automatic ascon_state_t linear_diffusion_layer(input ascon_state_t s);
    ascon_state_t r;
    r[0] = s[0] ^ ror64(s[0], 19) ^ ror64(s[0], 28);
    r[1] = s[1] ^ ror64(s[1], 61) ^ ror64(s[1], 39);
    r[2] = s[2] ^ ror64(s[2],  1) ^ ror64(s[2],  6);
    r[3] = s[3] ^ ror64(s[3], 10) ^ ror64(s[3], 17);
    r[4] = s[4] ^ ror64(s[4],  7) ^ ror64(s[4], 41);
    return r;
  endfunction

  function automatic ascon_state_t ascon_round(input ascon_state_t s, input logic [4:0] i);
    ascon_state_t r;
    r = s;
    r[2][7:0] = r[2][7:0] ^ round_const(i);
    r = sbox_layer(r);
    r = linear_diffusion_layer(r);
    return r;
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  fsm_e         fsm_q, fsm_d;
  ascon_state_t state_q, state_d;
  logic [4:0]   idx_q, idx_d;
  logic [4:0]   rem_q, rem_d;
  logic         out_valid_q, out_valid_d;

  logic [4:0]   rnd_clamped;
  logic [4:0]   k;
  ascon_state_t run_state;
  logic         accept;

  assign rnd_clamped = (rnd_i > MAX_RND) ? MAX_RND : rnd_i;

  assign in_ready_o  = (fsm_q == IDLE) | ((fsm_q == DONE) & out_ready_i);
  assign accept      = in_valid_i & in_ready_o;
  assign busy_o      = (fsm_q == RUN);
  assign out_valid_o = out_valid_q;
  assign state_o     = state_q;

  // Unrolled round chain. Stages at or beyond k pass the state through, so
  // the final pass of a job (and rnd = 0) only applies the rounds still owed.
  always_comb begin
    k         = (rem_q < UNROLL_L) ? rem_q : UNROLL_L;
    run_state = state_q;
    for (int unsigned s = 0; s < UNROLL; s++) begin
      if (5'(s) < k) begin
        run_state = ascon_round(run_state, idx_q + 5'(s));
      end
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    idx_d   = idx_q;
    rem_d   = rem_q;

    case (fsm_q)
      IDLE: begin
        if (accept) begin
          state_d = state_i;
          idx_d   = MAX_RND - rnd_clamped;
          rem_d   = rnd_clamped;
          fsm_d   = RUN;
        end
      end
      RUN: begin
        state_d = run_state;
        idx_d   = idx_q + k;
        rem_d   = rem_q - k;
        if (rem_q == k) begin
          fsm_d = DONE;
        end
      end
      DONE: begin
        if (out_ready_i) begin
          if (accept) begin
            state_d = state_i;
            idx_d   = MAX_RND - rnd_clamped;
            rem_d   = rnd_clamped;
            fsm_d   = RUN;
          end else begin
            fsm_d = IDLE;
          end
        end
      end
      default: fsm_d = IDLE;
    endcase

    out_valid_d = (fsm_d == DONE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fsm_q       <= IDLE;
      state_q     <= '0;
      idx_q       <= '0;
      rem_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      idx_q       <= idx_d;
      rem_q       <= rem_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_ascon_permutation_core.sv
// Testbench for ascon_permutation_core: four elaborations (UNROLL 1, 3, 4, 16)
// share one stimulus stream; results are compared with a table-driven
// software model of Ascon-p.
module tb_ascon_permutation_core;

  typedef logic [4:0][63:0] st_t;
  localparam int unsigned NDUT = 4;

  function automatic int unsigned unroll_of(input int unsigned g);
    case (g)
      0:       return 1;
      1:       return 3;
      2:       return 4;
      default: return 16;
    endcase
  endfunction

  logic       clk_i       = 1'b0;
  logic       rst_ni      = 1'b0;
  logic       in_valid_i  = 1'b0;
  logic       out_ready_i = 1'b0;
  st_t        state_i     = '0;
  logic [4:0] rnd_i       = '0;

  logic in_ready_o  [NDUT];
  logic out_valid_o [NDUT];
  logic busy_o      [NDUT];
  st_t  state_o     [NDUT];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Results captured by collect()
  int unsigned lat [NDUT];
  st_t         res [NDUT];
  bit          seen[NDUT];

  always #5 clk_i = ~clk_i;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    ascon_permutation_core #(.UNROLL(unroll_of(g))) u_dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .in_valid_i (in_valid_i),
      .in_ready_o (in_ready_o[g]),
      .state_i    (state_i),
      .rnd_i      (rnd_i),
      .out_valid_o(out_valid_o[g]),
      .out_ready_i(out_ready_i),
      .state_o    (state_o[g]),
      .busy_o     (busy_o[g])
    );
  end

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  logic [4:0] sbox_tab [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };
  int unsigned rot_a [5] = '{19, 61, 1, 10, 7};
  int unsigned rot_b [5] = '{28, 39, 6, 17, 41};

  function automatic logic [63:0] ror(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic st_t ascon_ref(input st_t s_in, input int unsigned rnd);
    st_t         s;
    int unsigned r;
    logic [7:0]  c;
    logic [4:0]  v, o;
    s = s_in;
    r = (rnd > 16) ? 16 : rnd;
    for (int unsigned i = 16 - r; i < 16; i++) begin
      c = 8'((((3 - i) & 15) << 4) | ((12 + i) & 15));
      s[2][7:0] = s[2][7:0] ^ c;
      for (int unsigned b = 0; b < 64; b++) begin
        v = {s[0][b], s[1][b], s[2][b], s[3][b], s[4][b]};
        o = sbox_tab[v];
        s[0][b] = o[4];
        s[1][b] = o[3];
        s[2][b] = o[2];
        s[3][b] = o[1];
        s[4][b] = o[0];
      end
      for (int unsigned j = 0; j < 5; j++) begin
        s[j] = s[j] ^ ror(s[j], rot_a[j]) ^ ror(s[j], rot_b[j]);
      end
    end
    return s;
  endfunction

  function automatic int unsigned exp_lat(input int unsigned rnd, input int unsigned u);
    int unsigned r;
    r = (rnd > 16) ? 16 : rnd;
    return (r == 0) ? 1 : (r + u - 1) / u;
  endfunction

  function automatic st_t rand_state();
    st_t s;
    for (int unsigned w = 0; w < 5; w++) begin
      s[w] = {$urandom, $urandom};
    end
    return s;
  endfunction

  // --------------------------------------------------------------------------
  // Stimulus helpers (all start and end 1 time unit after a rising edge)
  // --------------------------------------------------------------------------
  task automatic start_job(input st_t st, input logic [4:0] r);
    state_i     = st;
    rnd_i       = r;
    in_valid_i  = 1'b1;
    out_ready_i = 1'b0;
    @(posedge clk_i); #1;
    in_valid_i  = 1'b0;
    state_i     = rand_state();
    rnd_i       = 5'($urandom);
  endtask

  // Waits (bounded) until every instance reports out_valid_o; records the
  // latency in cycles after the accept edge and the first result seen.
  task automatic collect(output int unsigned busy_cnt);
    bit all_seen;
    busy_cnt = busy_o[0] ? 1 : 0;
    for (int unsigned g = 0; g < NDUT; g++) begin
      seen[g] = 1'b0;
      lat[g]  = 0;
      res[g]  = '0;
    end
    all_seen = 1'b0;
    for (int unsigned cyc = 1; cyc <= 40 && !all_seen; cyc++) begin
      @(posedge clk_i); #1;
      if (busy_o[0]) busy_cnt++;
      all_seen = 1'b1;
      for (int unsigned g = 0; g < NDUT; g++) begin
        if (!seen[g] && out_valid_o[g]) begin
          seen[g] = 1'b1;
          lat[g]  = cyc;
          res[g]  = state_o[g];
        end
        if (!seen[g]) all_seen = 1'b0;
      end
    end
  endtask

  task automatic drain();
    out_ready_i = 1'b1;
    @(posedge clk_i); #1;
    out_ready_i = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  // Scenarios
  // --------------------------------------------------------------------------
  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    for (int unsigned g = 0; g < NDUT; g++) begin
      n_checks++;
      if (out_valid_o[g] !== 1'b0 || busy_o[g] !== 1'b0 || in_ready_o[g] !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_ctrl u%0d: valid=%b busy=%b ready=%b expected 0 0 1",
                 unroll_of(g), out_valid_o[g], busy_o[g], in_ready_o[g]);
      end
      n_checks++;
      if (state_o[g] !== '0) begin
        n_fail++;
        $display("FAIL reset_state u%0d: got %h expected 0", unroll_of(g), state_o[g]);
      end
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_zero_state();
    st_t         exp;
    int unsigned bc;
    exp = ascon_ref('0, 12);
    start_job('0, 5'd12);
    collect(bc);
    for (int unsigned g = 0; g < NDUT; g++) begin
      n_checks++;
      if (lat[g] !== exp_lat(12, unroll_of(g))) begin
        n_fail++;
        $display("FAIL zero_lat u%0d: got %0d expected %0d", unroll_of(g), lat[g], exp_lat(12, unroll_of(g)));
      end
      n_checks++;
      if (res[g] !== exp) begin
        n_fail++;
        $display("FAIL zero_result u%0d: got %h expected %h", unroll_of(g), res[g], exp);
      end
    end
    n_checks++;
    if (bc !== 12) begin
      n_fail++;
      $display("FAIL zero_busy_cycles: got %0d expected 12", bc);
    end
    drain();
    for (int unsigned g = 0; g < NDUT; g++) begin
      n_checks++;
      if (out_valid_o[g] !== 1'b0 || in_ready_o[g] !== 1'b1) begin
        n_fail++;
        $display("FAIL zero_release u%0d: valid=%b ready=%b expected 0 1",
                 unroll_of(g), out_valid_o[g], in_ready_o[g]);
      end
    end
  endtask

  task automatic test_all_rounds();
    st_t         st, exp;
    int unsigned bc;
    for (int unsigned r = 0; r <= 16; r++) begin
      st  = rand_state();
      exp = ascon_ref(st, r);
      start_job(st, 5'(r));
      collect(bc);
      for (int unsigned g = 0; g < NDUT; g++) begin
        n_checks++;
        if (lat[g] !== exp_lat(r, unroll_of(g))) begin
          n_fail++;
          $display("FAIL rnd%0d_lat u%0d: got %0d expected %0d", r, unroll_of(g), lat[g], exp_lat(r, unroll_of(g)));
        end
        n_checks++;
        if (res[g] !== exp) begin
          n_fail++;
          $display("FAIL rnd%0d_result u%0d: got %h expected %h", r, unroll_of(g), res[g], exp);
        end
        if (r == 0) begin
          n_checks++;
          if (res[g] !== st) begin
            n_fail++;
            $display("FAIL rnd0_passthrough u%0d: got %h expected %h", unroll_of(g), res[g], st);
          end
        end
      end
      drain();
    end
  endtask

  task automatic test_back_to_back();
    st_t         st1, st2, exp2;
    logic [4:0]  r1, r2;
    int unsigned bc;
    st1 = rand_state();
    r1  = 5'($urandom_range(0, 16));
    start_job(st1, r1);
    collect(bc);
    for (int unsigned g = 0; g < NDUT; g++) begin
      n_checks++;
      if (res[g] !== ascon_ref(st1, r1)) begin
        n_fail++;
        $display("FAIL bp_result u%0d: got %h expected %h", unroll_of(g), res[g], ascon_ref(st1, r1));
      end
    end
    for (int unsigned c = 0; c < 10; c++) begin
      @(posedge clk_i); #1;
      for (int unsigned g = 0; g < NDUT; g++) begin
        n_checks++;
        if (out_valid_o[g] !== 1'b1 || in_ready_o[g] !== 1'b0 || state_o[g] !== res[g]) begin
          n_fail++;
          $display("FAIL bp_hold u%0d cyc%0d: valid=%b ready=%b state=%h expected 1 0 %h",
                   unroll_of(g), c, out_valid_o[g], in_ready_o[g], state_o[g], res[g]);
        end
      end
    end
    st2  = rand_state();
    r2   = 5'($urandom_range(0, 16));
    exp2 = ascon_ref(st2, r2);
    state_i     = st2;
    rnd_i       = r2;
    in_valid_i  = 1'b1;
    out_ready_i = 1'b1;
    #1;
    for (int unsigned g = 0; g < NDUT; g++) begin
      n_checks++;
      if (in_ready_o[g] !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_ready u%0d: got %b expected 1", unroll_of(g), in_ready_o[g]);
      end
    end
    @(posedge clk_i); #1;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    state_i     = rand_state();
    for (int unsigned g = 0; g < NDUT; g++) begin
      n_checks++;
      if (out_valid_o[g] !== 1'b0 || busy_o[g] !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_accept u%0d: valid=%b busy=%b expected 0 1", unroll_of(g), out_valid_o[g], busy_o[g]);
      end
    end
    collect(bc);
    for (int unsigned g = 0; g < NDUT; g++) begin
      n_checks++;
      if (lat[g] !== exp_lat(r2, unroll_of(g))) begin
        n_fail++;
        $display("FAIL b2b_lat u%0d: got %0d expected %0d", unroll_of(g), lat[g], exp_lat(r2, unroll_of(g)));
      end
      n_checks++;
      if (res[g] !== exp2) begin
        n_fail++;
        $display("FAIL b2b_result u%0d: got %h expected %h", unroll_of(g), res[g], exp2);
      end
    end
    drain();
  endtask

  task automatic test_input_change();
    st_t         st, exp;
    logic [4:0]  r;
    int unsigned bc;
    st  = rand_state();
    r   = 5'($urandom_range(1, 16));
    exp = ascon_ref(st, r);
    state_i     = st;
    rnd_i       = r;
    in_valid_i  = 1'b1;
    out_ready_i = 1'b0;
    @(posedge clk_i); #1;
    // Requester keeps in_valid high with different data while the core works.
    state_i = rand_state();
    rnd_i   = 5'($urandom);
    collect(bc);
    for (int unsigned g = 0; g < NDUT; g++) begin
      n_checks++;
      if (lat[g] !== exp_lat(r, unroll_of(g))) begin
        n_fail++;
        $display("FAIL chg_lat u%0d: got %0d expected %0d", unroll_of(g), lat[g], exp_lat(r, unroll_of(g)));
      end
      n_checks++;
      if (res[g] !== exp) begin
        n_fail++;
        $display("FAIL chg_result u%0d: got %h expected %h", unroll_of(g), res[g], exp);
      end
    end
    in_valid_i = 1'b0;
    drain();
  endtask

  task automatic test_async_reset();
    st_t         st, exp;
    logic [4:0]  r;
    int unsigned bc;
    start_job(rand_state(), 5'd12);
    repeat (4) @(posedge clk_i);
    #3;
    n_checks++;
    if (busy_o[0] !== 1'b1 || out_valid_o[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_pre u1: busy=%b valid=%b expected 1 0", busy_o[0], out_valid_o[0]);
    end
    rst_ni = 1'b0;
    #1;
    for (int unsigned g = 0; g < NDUT; g++) begin
      n_checks++;
      if (out_valid_o[g] !== 1'b0 || busy_o[g] !== 1'b0 || in_ready_o[g] !== 1'b1 || state_o[g] !== '0) begin
        n_fail++;
        $display("FAIL arst_immediate u%0d: valid=%b busy=%b ready=%b state=%h expected 0 0 1 0",
                 unroll_of(g), out_valid_o[g], busy_o[g], in_ready_o[g], state_o[g]);
      end
    end
    repeat (3) begin
      @(posedge clk_i); #1;
      n_checks++;
      if (out_valid_o[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL arst_no_pulse u1: got %b expected 0", out_valid_o[0]);
      end
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    st  = rand_state();
    r   = 5'($urandom_range(0, 16));
    exp = ascon_ref(st, r);
    start_job(st, r);
    collect(bc);
    for (int unsigned g = 0; g < NDUT; g++) begin
      n_checks++;
      if (res[g] !== exp || lat[g] !== exp_lat(r, unroll_of(g))) begin
        n_fail++;
        $display("FAIL arst_fresh u%0d: lat=%0d state=%h expected lat=%0d state=%h",
                 unroll_of(g), lat[g], res[g], exp_lat(r, unroll_of(g)), exp);
      end
    end
    drain();
  endtask

  task automatic test_clamp();
    st_t         st, exp;
    int unsigned bc;
    st  = rand_state();
    exp = ascon_ref(st, 16);
    start_job(st, 5'd31);
    collect(bc);
    for (int unsigned g = 0; g < NDUT; g++) begin
      n_checks++;
      if (lat[g] !== exp_lat(16, unroll_of(g))) begin
        n_fail++;
        $display("FAIL clamp_lat u%0d: got %0d expected %0d", unroll_of(g), lat[g], exp_lat(16, unroll_of(g)));
      end
      n_checks++;
      if (res[g] !== exp) begin
        n_fail++;
        $display("FAIL clamp_result u%0d: got %h expected %h", unroll_of(g), res[g], exp);
      end
    end
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_zero_state();
    test_all_rounds();
    test_back_to_back();
    test_input_change();
    test_async_reset();
    test_clamp();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ascon_permutation_core.md
# ascon_permutation_core

Iterative Ascon-p[rnd] permutation engine per NIST SP 800-232. It holds one 320-bit `ascon_state_t` and applies a configurable number of rounds with valid/ready handshakes on both sides. Each round is constant addition, the S-box layer, then `linear_diffusion_layer`. `UNROLL` rounds are instantiated combinationally per clock, so one core trades area for latency. The core sits between the mode controllers (AEAD, hash, XOF) and the round primitives.

## Interface
- `UNROLL`, default 1: rounds evaluated per clock; legal values 1..16.
- `clk_i` input, 1: clock, rising-edge.
- `rst_ni` input, 1: reset, asynchronous, active-low.
- `in_valid_i` input, 1: request valid.
- `in_ready_o` output, 1: core can accept a request.
- `state_i` input, `ascon_state_t` (5×64): state to permute.
- `rnd_i` input, 5: round count, 0..16. Values above 16 are clamped to 16.
- `out_valid_o` output, 1: result valid.
- `out_ready_i` input, 1: consumer accepts the result.
- `state_o` output, `ascon_state_t`: permuted state, registered.
- `busy_o` output, 1: high in RUN.

## Operation
- **FSM states:** IDLE, RUN, DONE.
- **Reset values:** FSM = IDLE, `state_o` = 0, `out_valid_o` = 0, `busy_o` = 0, `in_ready_o` = 1.
- **`in_ready_o` (combinational):** `in_ready_o = (IDLE) | (DONE & out_ready_i)`.
- **Accept:** occurs on `in_valid_i & in_ready_o`. The core loads `state_i` into the state register, sets the round index `idx = 16 - rnd` and `remaining = rnd`, then goes to RUN.
- **RUN, per cycle:**
  - Apply `k = min(UNROLL, remaining)` rounds, using indices `idx .. idx+k-1`.
  - Then `idx += k` and `remaining -= k`.
  - Unroll stages with stage number ≥ k are bypassed (identity).
  - When `remaining` reaches 0 after the update, go to DONE.
- **`rnd_i = 0`:** RUN lasts one cycle with all stages bypassed, so the state passes through unchanged.
- **Round i:**
  - Constant addition: `S2[7:0] ^= c_i`, with c_0..c_15 = 3c 2d 1e 0f f0 e1 d2 c3 b4 a5 96 87 78 69 5a 4b.
  - S-box: the 5-bit Ascon S-box applied bit-sliced across words S0..S4.
  - Linear diffusion: `Sj ^= ROR(Sj,a_j) ^ ROR(Sj,b_j)`, with a = 19,61,1,10,7 and b = 28,39,6,17,41.
- **Round indices:** `idx` is 5 bits and never exceeds 16; with rnd = 12 the core uses c_4..c_15.
- **DONE:**
  - `out_valid_o = 1`, and `state_o` holds the result.
  - On `out_ready_i`: with a new accept in the same cycle, go to RUN (back-to-back); otherwise go to IDLE.
  - Without `out_ready_i`, hold DONE and keep `state_o` stable.
- **Input stability:** `state_i` and `rnd_i` are sampled only on the accept edge; later changes have no effect.
- **`in_valid_i` while busy:** in RUN, `in_valid_i` is ignored (`in_ready_o` = 0), and the requester must hold it.
- **Asynchronous reset in any state:** immediate return to reset values. A partially permuted state is discarded, and no `out_valid_o` pulse occurs.

## Timing
- N = max(1, ceil(rnd/UNROLL)).
- **Latency:** accept at edge E0 gives `out_valid_o` high after edge E0+N.
  - UNROLL=1, rnd=12: N = 12.
  - UNROLL=4, rnd=6: N = 2 (4 rounds, then 2).
- **Throughput:** with `out_ready_i` held high and `in_valid_i` held high, one result every N+1 cycles. The DONE cycle overlaps the next accept.
- **Output timing:** `state_o` and `out_valid_o` are registered. `in_ready_o` is combinational from the FSM and `out_ready_i`.
- **Critical path:** UNROLL × (constant add + S-box + diffusion). UNROLL ≥ 4 is intended for low-frequency targets only.

## Test plan
- **Zero state, UNROLL=1, rnd=12, `out_ready_i`=1:** `out_valid_o` rises exactly 12 cycles after accept; `state_o` equals the bench software model of Ascon-p[12] on all-zero input; `busy_o` is high for 12 cycles.
- **Random states, all rnd 0..16, UNROLL ∈ {1,3,4,16} (separate elaborations):**
  - Every result matches the model.
  - Latency = max(1, ceil(rnd/UNROLL)); e.g. UNROLL=3, rnd=8 → 3 cycles.
  - rnd=0 returns `state_i` unchanged after 1 cycle.
- **Backpressure:** `out_ready_i`=0 for 10 cycles after DONE → `out_valid_o` stays 1, `state_o` is stable, and `in_ready_o`=0. Raise `out_ready_i` together with `in_valid_i` → handoff and new accept occur on the same edge, and the next `out_valid_o` appears N cycles later.
- **Input change after accept:** change `state_i` and `rnd_i` to random values the cycle after accept → the result reflects the originally sampled values only.
- **Async reset mid-RUN:** drop `rst_ni` 5 cycles into a rnd=12 job, between clock edges →
  - all outputs reach reset values immediately and `in_ready_o`=1;
  - no `out_valid_o` pulse occurs;
  - a fresh job afterwards produces the correct result.
- **Clamp:** `rnd_i`=31 behaves identically to 16 (uses c_0..c_15, same latency, same result).
